alu_rr_arbiter: RTL
===================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one combinational alu instance between NUM_REQ requesters (e.g. core datapath,
//  debug/test port). Requesters issue (a, b, op) with valid/ready; round-robin grant.
//  Operands are latched, evaluated once, and the result/flag returned on the granted
//  requester's response channel. Held until accepted. One op in flight at a time.
//  Opcodes are the 5-bit ALU_* encodings from alu_opcodes_pkg.
// PARAMETERS
//  NUM_REQ  2  number of requesters, >=2
//  IDX_W    $clog2(NUM_REQ)  width of grant index (derived, do not override)
// PORTS
//  clk_i         in   1             clock, rising edge
//  rst_i         in   1             asynchronous reset, active-high
//  req_valid_i   in   NUM_REQ       per-requester op valid
//  req_ready_o   out  NUM_REQ       per-requester op accepted (one-hot or zero)
//  req_a_i       in   NUM_REQ*32    operand A, requester k at [32k+31:32k]
//  req_b_i       in   NUM_REQ*32    operand B, same packing
//  req_op_i      in   NUM_REQ*5     ALU opcode, requester k at [5k+4:5k]
//  resp_valid_o  out  NUM_REQ       per-requester response valid (one-hot or zero)
//  resp_ready_i  in   NUM_REQ       per-requester response accept
//  resp_result_o out  32            result of the op in flight (shared bus)
//  resp_flag_o   out  1             branch flag of the op in flight (shared bus)
//  busy_o        out  1             high whenever state != IDLE
//  grant_idx_o   out  IDX_W         index of current or last granted requester
// BEHAVIOUR
//  Reset (async, while rst_i=1): state=IDLE, rr_ptr=0, grant_idx_o=0, resp_valid_o=0,
//   resp_result_o=0, resp_flag_o=0, req_ready_o=0, busy_o=0. Reset in any state aborts
//   the op in flight. No response is ever produced for an aborted op.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: g = first k with req_valid_i[k], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   If one is found: req_ready_o = onehot(g) combinationally in this cycle. On the clock edge,
//   latch a/b/op of g, set grant_idx_o=g, go to EXEC. If none is found: req_ready_o=0 and stay.
//  EXEC: alu is driven from the latched operands. Register result_o/flag_o into
//   resp_result_o/resp_flag_o, then go to RESP. req_ready_o=0.
//  RESP: resp_valid_o = onehot(grant_idx_o). Outputs are held stable.
//   When resp_ready_i[grant_idx_o]=1: go to IDLE, set rr_ptr=(grant_idx_o+1) mod NUM_REQ.
//   resp_ready_i bits of non-granted requesters are ignored. req_ready_o=0.
//  Latency: handshake in cycle N -> resp_valid_o in cycle N+2. Max throughput is 1 op / 3 cycles
//   (response accepted in its first cycle; the next grant can occur in the cycle after).
//  Simultaneous valids: exactly one grant, chosen by rr_ptr. Sustained contention alternates
//   fairly, and no requester waits more than NUM_REQ-1 ops.
//  Requester protocol: hold valid/operands stable until ready. Dropping valid before
//   ready is tolerated (not granted, no side effect).
//  Arithmetic: all results are 32-bit with wrap-around. For compare-type ops (EQ..GEU),
//   result=0 and the flag is valid. For arithmetic/logic ops, flag=0. Undefined opcodes give
//   result 0 and flag 0.
//  Outputs resp_result_o/flag_o keep their last value in IDLE (qualified by resp_valid_o).
// TESTING
//  1 Req0 ADD a=5 b=7, resp_ready tied 1 -> req_ready_o=01 in cycle 0, resp_valid_o=01
//    in cycle 2, result=12, flag=0, busy_o high cycles 1-2.
//  2 Both valid after reset: req0 XOR 0xF0/0x0F, req1 SUB 3-5 -> req0 served first
//    (result 0xFF), then req1 (result 0xFFFFFFFE). grant_idx_o goes 0 then 1.
//  3 Both valid continuously for 6 ops -> grant order 0,1,0,1,0,1, one op per 3 cycles.
//  4 Req1 SRA 0x80000000>>4, resp_ready_i[1]=0 for 4 cycles -> result 0xF8000000 held stable,
//    req_ready_o=00 throughout even with req0 valid. Req0 is granted the cycle after accept.
//  5 Req0 EQ a=b=9 -> flag=1, result=0. Req0 SLTS a=0xFFFFFFFF b=1 -> result=1, flag=0.
//    Req0 LTU same operands -> flag=0.
//  6 Assert rst_i during EXEC -> resp_valid_o=0 and busy_o=0 immediately, with no response
//    after release. The next single request from req1 is still granted normally.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NUM_REQ requesters.
// One op is in flight at a time; its result is held on the granted requester's response channel until accepted.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_a_i,
  input  logic [NUM_REQ*32-1:0] req_b_i,
  input  logic [NUM_REQ*5-1:0]  req_op_i,
  output logic [NUM_REQ-1:0]    resp_valid_o,
  input  logic [NUM_REQ-1:0]    resp_ready_i,
  output logic [31:0]           resp_result_o,
  output logic                  resp_flag_o,
  output logic                  busy_o,
  output logic [IDX_W-1:0]      grant_idx_o
);

  // state | meaning
  // IDLE  | arbitrating, ready pulsed to the round-robin winner
  // EXEC  | ALU evaluates latched operands, result registered
  // RESP  | response held to grant_idx_o until it is accepted
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLTS = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_EQ   = 5'd10;
  localparam logic [4:0] ALU_NE   = 5'd11;
  localparam logic [4:0] ALU_LTS  = 5'd12;
  localparam logic [4:0] ALU_GES  = 5'd13;
  localparam logic [4:0] ALU_LTU  = 5'd14;
  localparam logic [4:0] ALU_GEU  = 5'd15;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [4:0]         op_q, op_d;
  logic [31:0]        result_q, result_d;
  logic               flag_q, flag_d;

  logic               found;
  logic [IDX_W-1:0]   gnt;
  logic [NUM_REQ-1:0] ready_vec;
  logic [31:0]        sel_a, sel_b;
  logic [4:0]         sel_op;
  logic [31:0]        alu_result;
  logic               alu_flag;

  always_comb begin
    alu_result = '0;
    alu_flag   = 1'b0;
    case (op_q)
      ALU_ADD:  alu_result = a_q + b_q;
      ALU_SUB:  alu_result = a_q - b_q;
      ALU_AND:  alu_result = a_q & b_q;
      ALU_OR:   alu_result = a_q | b_q;
      ALU_XOR:  alu_result = a_q ^ b_q;
      ALU_SLL:  alu_result = a_q << b_q[4:0];
      ALU_SRL:  alu_result = a_q >> b_q[4:0];
      ALU_SRA:  alu_result = $unsigned($signed(a_q) >>> b_q[4:0]);
      ALU_SLTS: alu_result = {31'd0, ($signed(a_q) < $signed(b_q))};
      ALU_SLTU: alu_result = {31'd0, (a_q < b_q)};
      ALU_EQ:   alu_flag   = (a_q == b_q);
      ALU_NE:   alu_flag   = (a_q != b_q);
      ALU_LTS:  alu_flag   = ($signed(a_q) < $signed(b_q));
      ALU_GES:  alu_flag   = ($signed(a_q) >= $signed(b_q));
      ALU_LTU:  alu_flag   = (a_q < b_q);
      ALU_GEU:  alu_flag   = (a_q >= b_q);
      default: ;
    endcase
  end

  // First pass covers rr_ptr..NUM_REQ-1, second pass wraps to the low indices.
  always_comb begin
    found     = 1'b0;
    gnt       = '0;
    ready_vec = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    for (int p = 0; p < 2 * NUM_REQ; p++) begin
      if (!found && req_valid_i[p % NUM_REQ] &&
          ((p >= NUM_REQ) || (p >= int'(rr_ptr_q)))) begin
        found                     = 1'b1;
        gnt                       = IDX_W'(p % NUM_REQ);
        ready_vec[p % NUM_REQ]    = 1'b1;
        sel_a                     = req_a_i[32*(p % NUM_REQ) +: 32];
        sel_b                     = req_b_i[32*(p % NUM_REQ) +: 32];
        sel_op                    = req_op_i[5*(p % NUM_REQ) +: 5];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    flag_d       = flag_q;
    req_ready_o  = '0;
    resp_valid_o = '0;
    case (state_q)
      IDLE: begin
        if (found && !rst_i) begin
          req_ready_o = ready_vec;
          grant_d     = gnt;
          a_d         = sel_a;
          b_d         = sel_b;
          op_d        = sel_op;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        flag_d   = alu_flag;
        state_d  = RESP;
      end
      RESP: begin
        resp_valid_o[grant_q] = 1'b1;
        if (resp_ready_i[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign resp_result_o = result_q;
  assign resp_flag_o   = flag_q;
  assign busy_o        = (state_q != IDLE);
  assign grant_idx_o   = grant_q;

endmodule
